// File: rtl/pwm_pkg.sv
// PWM generator shared types: FSM state encoding and default counter width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pwm_pkg;

    // Default width of the counter, duty and period buses.
    localparam int PWM_CNT_W = 12;

    // Duty-update handshake states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLAMP = 2'd1,
        READY = 2'd2,
        ARMED = 2'd3
    } pwm_state_t;

endpackage

// File: rtl/pwm_deadtime.sv
// Dead-time insertion: delays each rising edge of both drive legs by DEAD_CYC cycles.
// Latency: rising edges +DEAD_CYC cycles, falling edges follow pwm_raw combinationally.
// Backpressure: none; free-running on every clock.
//
// Ports:
//   clk, n_rst  - clock and asynchronous active-low reset
//   pwm_raw     - registered raw PWM from the period counter
//   pwm_hi      - high-side drive, high only after pwm_raw has been high DEAD_CYC cycles
//   pwm_lo      - low-side drive, high only after pwm_raw has been low DEAD_CYC cycles
module pwm_deadtime #(
    parameter int DEAD_CYC = 4
) (
    input  logic clk,
    input  logic n_rst,
    input  logic pwm_raw,
    output logic pwm_hi,
    output logic pwm_lo
);

    localparam int DW = (DEAD_CYC < 1) ? 1 : $clog2(DEAD_CYC + 1);
    localparam logic [DW-1:0] DEAD_V = DW'(DEAD_CYC);

    // Each counter measures how long pwm_raw has held its current level,
    // saturating at DEAD_V. A leg may only turn on once its counter saturates,
    // and it drops the instant pwm_raw leaves its level, so the two legs can
    // never overlap and every hand-over has DEAD_CYC cycles of both-off.
    logic [DW-1:0] hi_cnt;
    logic [DW-1:0] lo_cnt;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            hi_cnt <= '0;
            lo_cnt <= '0;
        end else begin
            if (!pwm_raw) begin
                hi_cnt <= '0;
            end else if (hi_cnt != DEAD_V) begin
                hi_cnt <= hi_cnt + 1'b1;
            end

            if (pwm_raw) begin
                lo_cnt <= '0;
            end else if (lo_cnt != DEAD_V) begin
                lo_cnt <= lo_cnt + 1'b1;
            end
        end
    end

    assign pwm_hi = pwm_raw && (hi_cnt == DEAD_V);
    assign pwm_lo = !pwm_raw && (lo_cnt == DEAD_V);

endmodule

// File: rtl/pwm_gen.sv
// PWM generator with clamped, wrap-synchronised duty updates and optional dead time.
// Latency: pwm_rdy 2 cycles after pwm_enable; committed duty applies from cnt==0 after the next wrap.
// Backpressure: pwm_enable/pwm_chg outside the accepting states are dropped, never queued.
//
// Ports:
//   clk, n_rst  - clock and asynchronous active-low reset
//   pwm_enable  - strobe: latch duty_in as a new pending request
//   duty_in     - signed requested on-time (clamped to 0..DUTY_MAX)
//   pwm_chg     - strobe: commit the pending duty at the next period wrap
//   period      - PWM period in clk cycles, sampled at each wrap (minimum 2)
//   pwm_rdy     - a clamped duty is pending and may be committed
//   fm_cycle    - one-cycle pulse in the last cycle of each period
//   pwm_out     - high-side drive
//   pwm_out_n   - low-side drive (complement with dead time, else held 0)
//
// Build option: define PWM_GEN_DEADTIME_EN to insert DEAD_CYC cycles of dead
// time on every rising edge of pwm_out and pwm_out_n.
module pwm_gen
    import pwm_pkg::*;
#(
    parameter int CNT_W    = PWM_CNT_W,
    parameter int DUTY_MAX = 4000,
    parameter int DEAD_CYC = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    pwm_enable,
    input  logic signed [CNT_W-1:0] duty_in,
    input  logic                    pwm_chg,
    input  logic        [CNT_W-1:0] period,
    output logic                    pwm_rdy,
    output logic                    fm_cycle,
    output logic                    pwm_out,
    output logic                    pwm_out_n
);

    localparam logic [CNT_W-1:0] DUTY_MAX_V = CNT_W'(DUTY_MAX);
    localparam logic [CNT_W-1:0] PERIOD_MIN = CNT_W'(2);

    pwm_state_t state;
    pwm_state_t state_nxt;

    logic signed [CNT_W-1:0] pend_raw;
    logic        [CNT_W-1:0] pend_duty;
    logic        [CNT_W-1:0] clamp_val;
    logic        [CNT_W-1:0] act_duty;
    logic        [CNT_W-1:0] act_period;
    logic        [CNT_W-1:0] cnt;
    logic        [CNT_W-1:0] cnt_nxt;
    logic        [CNT_W-1:0] duty_nxt;
    logic                    wrap;
    logic                    commit;
    logic                    latch_raw;
    logic                    pwm_raw;

    // ------------------------------------------------------------------
    // Period counter
    // ------------------------------------------------------------------
    assign wrap    = (cnt == act_period - 1'b1);
    assign cnt_nxt = wrap ? '0 : cnt + 1'b1;

    // Commit only fires when the FSM was already ARMED going into the wrap
    // cycle, so a pwm_chg that lands on a wrap waits one full period.
    assign commit   = (state == ARMED) && wrap;
    assign duty_nxt = commit ? pend_duty : act_duty;

    // ------------------------------------------------------------------
    // Duty-update FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        latch_raw = 1'b0;
        case (state)
            IDLE: begin
                if (pwm_enable) begin
                    state_nxt = CLAMP;
                    latch_raw = 1'b1;
                end
            end
            CLAMP: begin
                state_nxt = READY;
            end
            READY: begin
                // pwm_chg has priority; a simultaneous pwm_enable is dropped.
                if (pwm_chg) begin
                    state_nxt = ARMED;
                end else if (pwm_enable) begin
                    state_nxt = CLAMP;
                    latch_raw = 1'b1;
                end
            end
            ARMED: begin
                if (wrap) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Saturate the signed request into 0..DUTY_MAX. The upper compare is only
    // reached for non-negative values, so an unsigned compare is exact.
    always_comb begin
        clamp_val = $unsigned(pend_raw);
        if (pend_raw[CNT_W-1]) begin
            clamp_val = '0;
        end else if ($unsigned(pend_raw) > DUTY_MAX_V) begin
            clamp_val = DUTY_MAX_V;
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            pend_raw   <= '0;
            pend_duty  <= '0;
            act_duty   <= '0;
            act_period <= PERIOD_MIN;
            cnt        <= '0;
            pwm_raw    <= 1'b0;
        end else begin
            if (latch_raw) begin
                pend_raw <= duty_in;
            end
            if (state == CLAMP) begin
                pend_duty <= clamp_val;
            end
            if (wrap) begin
                act_period <= (period < PERIOD_MIN) ? PERIOD_MIN : period;
            end
            cnt      <= cnt_nxt;
            act_duty <= duty_nxt;
            // Computed from next-cycle values so pwm_raw lines up with cnt and
            // a new duty shows from the very first cnt==0 cycle.
            pwm_raw  <= (cnt_nxt < duty_nxt);
        end
    end

    assign pwm_rdy  = (state == READY);
    assign fm_cycle = wrap;

    // ------------------------------------------------------------------
    // Output drive
    // ------------------------------------------------------------------
`ifdef PWM_GEN_DEADTIME_EN
    pwm_deadtime #(
        .DEAD_CYC (DEAD_CYC)
    ) u_deadtime (
        .clk     (clk),
        .n_rst   (n_rst),
        .pwm_raw (pwm_raw),
        .pwm_hi  (pwm_out),
        .pwm_lo  (pwm_out_n)
    );
`else
    assign pwm_out   = pwm_raw;
    assign pwm_out_n = 1'b0;

    // Keeps the dead-time parameter referenced when the feature is compiled out.
    logic unused_dead_cyc;
    assign unused_dead_cyc = ^DEAD_CYC;
`endif

endmodule

// File: tb/tb_pwm_gen.sv
// Directed bench for pwm_gen: behavioural model checked every cycle plus literal period measurements.
// Latency: n/a.
// Backpressure: n/a.
module tb_pwm_gen;

    // 13 bits so that duty_in = 4095 is a positive request that hits the
    // DUTY_MAX clamp while -5 is still a negative one.
    localparam int CNT_W = 13;
    localparam int DMAX  = 4000;
`ifdef PWM_GEN_DEADTIME_EN
    localparam int DT = 4;
`else
    localparam int DT = 0;
`endif

    logic                    clk;
    logic                    n_rst;
    logic                    pwm_enable;
    logic signed [CNT_W-1:0] duty_in;
    logic                    pwm_chg;
    logic        [CNT_W-1:0] period;
    logic                    pwm_rdy;
    logic                    fm_cycle;
    logic                    pwm_out;
    logic                    pwm_out_n;

    int n_vec = 0;
    int n_bad = 0;

    pwm_gen #(
        .CNT_W    (CNT_W),
        .DUTY_MAX (DMAX),
        .DEAD_CYC (4)
    ) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .pwm_enable (pwm_enable),
        .duty_in    (duty_in),
        .pwm_chg    (pwm_chg),
        .period     (period),
        .pwm_rdy    (pwm_rdy),
        .fm_cycle   (fm_cycle),
        .pwm_out    (pwm_out),
        .pwm_out_n  (pwm_out_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: period position/length, active duty, one pending
    // request with the cycle it becomes committable, a commit-waiting flag,
    // and a short history of raw PWM levels for the dead-time rule.
    // ------------------------------------------------------------------
    int m_pos = 0;
    int m_len = 2;
    int m_duty = 0;
    int pend_val = 0;
    int pend_ready_cyc = 0;
    int cyc = 0;
    bit has_pend = 0;
    bit commit_wait = 0;
    bit hist [DT+1];

    function automatic int clamp_duty(input int v);
        if (v < 0) return 0;
        if (v > DMAX) return DMAX;
        return v;
    endfunction

    always @(posedge clk) begin : model
        bit ready_now;
        bit at_wrap;
        if (!n_rst) begin
            m_pos       = 0;
            m_len       = 2;
            m_duty      = 0;
            has_pend    = 0;
            commit_wait = 0;
            hist[0]     = 0;
            for (int i = 1; i <= DT; i++) hist[i] = 1;
        end else begin
            ready_now = has_pend && !commit_wait && (cyc >= pend_ready_cyc);
            at_wrap   = (m_pos == m_len - 1);
            if (commit_wait) begin
                if (at_wrap) begin
                    m_duty      = pend_val;
                    commit_wait = 0;
                    has_pend    = 0;
                end
            end else if (ready_now && pwm_chg) begin
                commit_wait = 1;
            end else if (pwm_enable && (!has_pend || ready_now)) begin
                has_pend       = 1;
                pend_val       = clamp_duty(int'(duty_in));
                pend_ready_cyc = cyc + 2;
            end
            if (at_wrap) begin
                m_pos = 0;
                m_len = (int'(period) < 2) ? 2 : int'(period);
            end else begin
                m_pos++;
            end
            for (int i = DT; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = (m_pos < m_duty);
        end
        cyc++;
    end

    always @(negedge clk) begin : compare
        bit e_out;
        bit e_out_n;
        if (!n_rst) begin
            check("rst_pwm_rdy",   int'(pwm_rdy),   0);
            check("rst_fm_cycle",  int'(fm_cycle),  0);
            check("rst_pwm_out",   int'(pwm_out),   0);
            check("rst_pwm_out_n", int'(pwm_out_n), 0);
        end else begin
            e_out   = 1;
            e_out_n = 1;
            for (int i = 0; i <= DT; i++) begin
                if (!hist[i]) e_out = 0;
                if (hist[i])  e_out_n = 0;
            end
`ifndef PWM_GEN_DEADTIME_EN
            e_out_n = 0;
`endif
            check("cmp_pwm_out",   int'(pwm_out),   int'(e_out));
            check("cmp_pwm_out_n", int'(pwm_out_n), int'(e_out_n));
            check("cmp_fm_cycle",  int'(fm_cycle),  int'(m_pos == m_len - 1));
            check("cmp_pwm_rdy",   int'(pwm_rdy),
                  int'(has_pend && !commit_wait && (cyc >= pend_ready_cyc)));
            check("cmp_no_overlap", int'(pwm_out && pwm_out_n), 0);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_duty(input int d);
        int n;
        duty_in    = CNT_W'(d);
        pwm_enable = 1'b1;
        tick();
        pwm_enable = 1'b0;
        n = 1;
        while (!pwm_rdy && n < 10) begin
            tick();
            n++;
        end
        check("rdy_latency", n, 2);
    endtask

    task automatic commit_now();
        pwm_chg = 1'b1;
        tick();
        pwm_chg = 1'b0;
    endtask

    task automatic wait_wrap();
        int n = 0;
        while (!fm_cycle && n < 300) begin
            tick();
            n++;
        end
        check("wrap_seen", int'(fm_cycle), 1);
    endtask

    task automatic count(input int len, output int hi, output int both_lo, output int fm_n);
        hi = 0;
        both_lo = 0;
        fm_n = 0;
        for (int i = 0; i < len; i++) begin
            hi      += int'(pwm_out);
            both_lo += int'(!pwm_out && !pwm_out_n);
            fm_n    += int'(fm_cycle);
            tick();
        end
    endtask

    // Waits for a wrap, then measures the whole following 100-cycle period.
    task automatic measure(output int hi, output int both_lo, output int fm_n);
        wait_wrap();
        tick();
        count(100, hi, both_lo, fm_n);
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin : stim
        int hi;
        int blo;
        int fmn;

        n_rst      = 1'b0;
        pwm_enable = 1'b0;
        pwm_chg    = 1'b0;
        duty_in    = '0;
        period     = CNT_W'(100);

        repeat (3) tick();
        check("init_pwm_rdy",   int'(pwm_rdy),   0);
        check("init_fm_cycle",  int'(fm_cycle),  0);
        check("init_pwm_out",   int'(pwm_out),   0);
        check("init_pwm_out_n", int'(pwm_out_n), 0);
        n_rst = 1'b1;
        repeat (2) tick();

        // Duty 30 of period 100.
        load_duty(30);
        commit_now();
        measure(hi, blo, fmn);
        check("d30_high", hi, 30 - DT);
        check("d30_both_low", blo, (DT > 0) ? 2 * DT : 70);
        check("d30_fm_count", fmn, 1);

        // Negative request clamps to 0.
        load_duty(-5);
        commit_now();
        measure(hi, blo, fmn);
        check("dneg_high", hi, 0);

        // Over-range request clamps to DUTY_MAX -> permanently high at period 100.
        load_duty(4095);
        commit_now();
        measure(hi, blo, fmn);
        check("dmax_high", hi, 100 - DT);

        // pwm_chg 3 cycles before a wrap: old 100% duty holds to the wrap.
        load_duty(60);
        wait_wrap();
        repeat (97) tick();
        commit_now();
        count(3, hi, blo, fmn);
        check("late_chg_old_high", hi, 3);
        check("late_chg_wrap", fmn, 1);
        count(100, hi, blo, fmn);
        check("late_chg_new_high", hi, 60);

        // pwm_enable + pwm_chg together in READY: pending 30 wins, 50 dropped.
        load_duty(30);
        duty_in    = CNT_W'(50);
        pwm_enable = 1'b1;
        pwm_chg    = 1'b1;
        tick();
        pwm_enable = 1'b0;
        pwm_chg    = 1'b0;
        measure(hi, blo, fmn);
        check("both_strobe_high", hi, 30 - DT);

        // pwm_chg in the wrap cycle itself: commit waits a full period.
        load_duty(10);
        wait_wrap();
        commit_now();
        count(100, hi, blo, fmn);
        check("wrap_chg_old_high", hi, 30 - DT);
        count(100, hi, blo, fmn);
        check("wrap_chg_new_high", hi, 10 - DT);

        // Reset while ARMED: pending duty discarded, no commit afterwards.
        load_duty(70);
        commit_now();
        repeat (5) tick();
        n_rst = 1'b0;
        repeat (3) tick();
        check("armed_rst_pwm_out",  int'(pwm_out),  0);
        check("armed_rst_pwm_rdy",  int'(pwm_rdy),  0);
        check("armed_rst_fm_cycle", int'(fm_cycle), 0);
        n_rst = 1'b1;
        measure(hi, blo, fmn);
        check("post_rst_high", hi, 0);
        check("post_rst_fm_count", fmn, 1);
        check("post_rst_rdy", int'(pwm_rdy), 0);

        // Period below 2 is treated as 2.
        period = CNT_W'(1);
        wait_wrap();
        tick();
        count(10, hi, blo, fmn);
        check("min_period_fm_count", fmn, 5);
        period = CNT_W'(100);
        repeat (5) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/pwm_gen.md
PWM_GEN -- requirements
Module: pwm_gen

Interface
REQ-001 The block SHALL take parameter CNT_W, default 12, as the counter, duty and period width.
REQ-002 The block SHALL take parameter DUTY_MAX, default 4000, as the upper duty clamp in clk cycles.
REQ-003 The block SHALL take parameter DEAD_CYC, default 4, as the dead time in clk cycles, used only under the macro.
REQ-004 The block SHALL provide port clk, input, 1 bit: the clock; all logic is on its rising edge.
REQ-005 The block SHALL provide port n_rst, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL provide port pwm_enable, input, 1 bit: one-cycle strobe that latches duty_in.
REQ-007 The block SHALL provide port duty_in, input, CNT_W bits, signed: the requested on-time from the PID sum.
REQ-008 The block SHALL provide port pwm_chg, input, 1 bit: one-cycle strobe that commits the pending duty.
REQ-009 The block SHALL provide port period, input, CNT_W bits, unsigned: the PWM period in clk cycles.
REQ-010 The block SHALL provide port pwm_rdy, output, 1 bit: high while a clamped duty is pending.
REQ-011 The block SHALL provide port fm_cycle, output, 1 bit: one-cycle pulse at each period wrap.
REQ-012 The block SHALL provide port pwm_out, output, 1 bit: the high-side drive.
REQ-013 The block SHALL provide port pwm_out_n, output, 1 bit: the complementary low-side drive.

Function
REQ-014 The block SHALL implement FSM states IDLE, CLAMP, READY and ARMED.
REQ-015 The FSM SHALL move IDLE->CLAMP on pwm_enable, latching duty_in into pend_raw.
REQ-016 CLAMP SHALL last exactly one cycle: pend_duty = 0 if pend_raw < 0, DUTY_MAX if pend_raw > DUTY_MAX, otherwise pend_raw; the FSM then goes to READY.
REQ-017 pwm_rdy SHALL be 1 only in READY, first asserting 2 cycles after the pwm_enable strobe.
REQ-018 In READY, pwm_chg SHALL move the FSM to ARMED; pwm_enable without pwm_chg SHALL re-latch duty_in and return to CLAMP.
REQ-019 When pwm_enable and pwm_chg arrive together in READY, pwm_chg SHALL win and duty_in SHALL be ignored.
REQ-020 In ARMED, pwm_enable and pwm_chg SHALL be ignored; at the next period wrap, act_duty <= pend_duty and the FSM goes to IDLE.
REQ-021 pwm_chg outside READY and pwm_enable in CLAMP or ARMED SHALL be ignored.
REQ-022 cnt SHALL count 0..act_period-1 and wrap to 0; the wrap cycle is the cycle in which cnt == act_period-1.
REQ-023 fm_cycle SHALL be 1 exactly in the wrap cycle.
REQ-024 act_period SHALL be loaded from period only at wrap; a period value below 2 SHALL be treated as 2.
REQ-025 pwm_out SHALL be registered as (cnt < act_duty), so act_duty >= act_period gives 100% duty and act_duty = 0 gives constant low.
REQ-026 The new act_duty SHALL take effect on pwm_out from the first cycle with cnt == 0 after the wrap; no partial periods are allowed.
REQ-027 When a wrap occurs in the same cycle ARMED is entered, the commit SHALL wait for the following wrap.

Reset
REQ-028 On n_rst low, the block SHALL asynchronously set state=IDLE, cnt=0, act_duty=0, pend_raw=0, pend_duty=0 and act_period=2.
REQ-029 During reset, pwm_rdy, fm_cycle, pwm_out and pwm_out_n SHALL all be 0.
REQ-030 Reset mid-operation SHALL discard any pending duty and leave no commit outstanding.

Configuration
REQ-031 The block SHALL support macro PWM_GEN_DEADTIME_EN.
REQ-032 With PWM_GEN_DEADTIME_EN defined, each rising edge of pwm_out and of pwm_out_n SHALL be delayed by DEAD_CYC cycles, and the outputs SHALL never be high together.
REQ-033 With PWM_GEN_DEADTIME_EN defined, pwm_out_n SHALL be the complement of the raw PWM.
REQ-034 Without PWM_GEN_DEADTIME_EN, pwm_out SHALL equal the raw PWM, pwm_out_n SHALL be held at 0, and DEAD_CYC SHALL be unused.

Structure
REQ-035 Package pwm_pkg SHALL hold the FSM state enum typedef and the CNT_W default constant.
REQ-036 Sub-module pwm_deadtime SHALL hold the per-edge dead-time counters and SHALL be instantiated only under PWM_GEN_DEADTIME_EN.

Verification
REQ-037 The bench SHALL cover: period=100, pwm_enable with duty_in=30, pwm_chg on the first pwm_rdy -> from the next wrap, 30 high / 70 low per period, and fm_cycle every 100 cycles.
REQ-038 The bench SHALL cover: duty_in=-5 -> act_duty 0, pwm_out constant 0; duty_in=4095 -> act_duty 4000, pwm_out constant high at period=100.
REQ-039 The bench SHALL cover: pwm_enable and pwm_chg together in READY with duty_in=50 -> the prior pending 30 is committed and 50 is dropped.
REQ-040 The bench SHALL cover: pwm_chg sent 3 cycles before a wrap -> the old duty is kept until cnt returns to 0, and the output shows no glitch.
REQ-041 The bench SHALL cover: n_rst pulsed while ARMED -> all outputs 0, and after release act_duty stays 0 with no commit at the next wrap.
REQ-042 The bench SHALL cover, with PWM_GEN_DEADTIME_EN and DEAD_CYC=4 -> pwm_out and pwm_out_n are never high together, with a 4-cycle gap at each transition.
